serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder that consumes the sum/carry of the team's existing halfadder cell.
- Two halfadder instances plus an OR gate form a full adder, which is fed one operand bit per clock, LSB first, with the carry held in a flip-flop.
- Sits after the adder cells in the lab datapath; it is the small-area, sequential alternative to a ripple adder.
- Start/busy/done handshake to the upstream controller.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk    input   1      rising-edge clock
- reset  input   1      synchronous, active-high reset
- start  input   1      request; sampled only in IDLE
- a      input   WIDTH  operand A; captured on accepted start
- b      input   WIDTH  operand B; captured on accepted start
- busy   output  1      high while in SHIFT
- done   output  1      one-cycle pulse when sum/cout become valid
- sum    output  WIDTH  result, held stable from done until next accepted start
- cout   output  1      final carry out, held with sum
- s_bit  output  1      registered current serial sum bit (debug/observation)

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, sum=0, cout=0, s_bit=0. Internal state: FSM=IDLE, carry FF=0, bit counter=0, shift regs=0.
- Reset has priority over every other event, including mid-SHIFT: the operation is abandoned, no done pulse, and sum is cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures a and b into shift registers, clears carry (set to 1 when SUB active, see below) and clears the counter.
  - busy goes 1 in the next cycle; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each cycle:
  - Full adder combines a_sh[0], b_sh[0] and carry.
  - Sum bit shifts into the MSB of the sum shift register (sum register fills MSB-first, so the LSB ends at bit 0 after WIDTH shifts).
  - Carry FF is updated, s_bit gets the sum bit, a_sh and b_sh shift right, and the counter increments.
  - After exactly WIDTH SHIFT cycles (counter==WIDTH-1 on the last one), go to DONE.
- DONE (1 cycle):
  - sum is loaded from the sum shift register and cout from the carry FF.
  - done=1, busy=0; return to IDLE.
- Latency: accepted start at edge N produces done=1 in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles from start to the done pulse.
- start asserted while busy or in DONE is ignored; there is no queueing.
- Back-to-back operation: start may be asserted in the cycle done is high. The FSM is then back in IDLE, so the start is accepted on the next edge; minimum issue interval is WIDTH+2 cycles.
- a and b may change freely after capture.
- Arithmetic: {cout,sum} = a + b modulo 2^(WIDTH+1), unsigned.
- Overflow: all-ones + 1 gives sum=0, cout=1.
- Counter width: $clog2(WIDTH)+1 bits.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra port "sub" (input, 1) is sampled with start.
  - If sub=1, b is captured inverted and the carry FF is initialised to 1, giving sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow (a >= b unsigned).
  - Latency is unchanged.
- Undefined:
  - No sub port; the carry FF is always initialised to 0.

Decomposition:
- Package serial_adder_pkg:
  - state enum typedef (IDLE, SHIFT, DONE; 2-bit encoding)
  - localparam DEFAULT_WIDTH=8
  - function cnt_w(width) returning $clog2(width)+1
- One sub-module, full_adder: two halfadder instances plus OR for carry; purely combinational. It is the natural split, and the only place the existing halfadder is reused.

Test Plan:
- Reset then idle: hold reset 3 cycles -> busy=0, done=0, sum=0, cout=0. Then 10 idle cycles with start=0 -> outputs unchanged.
- Basic add, WIDTH=8: a=8'h35, b=8'h1C, start 1 cycle -> done pulse exactly 10 cycles later; sum=8'h51, cout=0; busy high for exactly 8 cycles.
- Overflow: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1.
- Ignored/back-to-back start: a=8'h0F, b=8'h01.
  - Pulse start again mid-SHIFT with a=8'hAA -> result still 8'h10; no extra done.
  - Start asserted in the done cycle with a=8'h02, b=8'h03 -> second done 10 cycles after acceptance with sum=8'h05.
- Reset mid-operation: start a=8'h80, b=8'h80, assert reset on the 4th SHIFT cycle -> next cycle busy=0, sum=0, cout=0; no done ever pulses. A fresh add afterwards returns the correct result.
- SERIAL_ADDER_SUB_EN build: a=8'h10, b=8'h01, sub=1 -> sum=8'h0F, cout=1. Then a=8'h01, b=8'h02, sub=1 -> sum=8'hFF, cout=0.
- Randomized scoreboard: 200 random pairs per WIDTH in {2,8,32}, compared against a+b.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state type, default width and counter sizing for serial_adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter must reach WIDTH after the final shift without wrapping
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/halfadder.sv
// rtl/halfadder.sv - single-bit half adder cell
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - combinational full adder built from two halfadder cells
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    halfadder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    // The two half-adder carries can never both be set, so OR merges them
    assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder with start/busy/done handshake; SERIAL_ADDER_SUB_EN adds a subtract mode
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             s_bit
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             s_bit_q;

    logic             s_d;
    logic             carry_d;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (s_d),
        .cout (carry_d)
    );

    // Control FSM and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            s_bit_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q <= a;
`ifdef SERIAL_ADDER_SUB_EN
                        // Two's-complement subtract: invert b and inject a carry of one
                        b_sh_q  <= sub ? ~b : b;
                        carry_q <= sub;
`else
                        b_sh_q  <= b;
                        carry_q <= 1'b0;
`endif
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts
                    sum_sh_q <= {s_d, sum_sh_q[WIDTH-1:1]};
                    carry_q  <= carry_d;
                    s_bit_q  <= s_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    sum_q   <= sum_sh_q;
                    cout_q  <= carry_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign s_bit = s_bit_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH 2, 8 and 32
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sub_r;
    logic [31:0] a_r;
    logic [31:0] b_r;

    int errors = 0;
    int checks = 0;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gw
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 8 : 32);

        logic         busy;
        logic         done;
        logic         cout;
        logic         s_bit;
        logic [W-1:0] sum;

        serial_adder #(.WIDTH(W)) dut (
            .clk   (clk),
            .reset (reset),
            .start (start),
            .a     (a_r[W-1:0]),
            .b     (b_r[W-1:0]),
`ifdef SERIAL_ADDER_SUB_EN
            .sub   (sub_r),
`endif
            .busy  (busy),
            .done  (done),
            .sum   (sum),
            .cout  (cout),
            .s_bit (s_bit)
        );

        int         e      = 0;
        int         acc    = 0;
        int         n_done = 0;
        bit         active = 1'b0;
        bit         sb     = 1'b0;
        logic [W:0] res    = '0;
        logic [W:0] held   = '0;
        logic [W:0] opb;

        // Reference model: timing from the accept edge, result from plain arithmetic
        always @(posedge clk) begin
            e++;
            if (reset) begin
                active = 1'b0;
                held   = '0;
                sb     = 1'b0;
            end else begin
                if (active && e == acc + W + 1) begin
                    held = res;
                    n_done++;
                end
                if (active && e >= acc + 1 && e <= acc + W)
                    sb = res[e - acc - 1];
                if (start && (!active || e >= acc + W + 2)) begin
                    acc    = e;
                    active = 1'b1;
                    opb    = (SUB_EN && sub_r) ? {1'b0, ~b_r[W-1:0]} : {1'b0, b_r[W-1:0]};
                    res    = {1'b0, a_r[W-1:0]} + opb + {{W{1'b0}}, (SUB_EN && sub_r)};
                end
            end
        end

        // Every-cycle comparison of all outputs against the model
        always @(negedge clk) begin
            if (e > 0) begin
                check($sformatf("w%0d_busy", W),  busy,  (active && e >= acc && e <= acc + W - 1));
                check($sformatf("w%0d_done", W),  done,  (active && e == acc + W + 1));
                check($sformatf("w%0d_sum", W),   sum,   held[W-1:0]);
                check($sformatf("w%0d_cout", W),  cout,  held[W]);
                check($sformatf("w%0d_s_bit", W), s_bit, sb);
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [8:0] r, output int lat, output int bc);
        a_r   = {24'h0, a};
        b_r   = {24'h0, b};
        sub_r = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bc    = 0;
        if (gw[1].busy) bc++;
        while (!gw[1].done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (gw[1].busy) bc++;
        end
        r = {gw[1].cout, gw[1].sum};
    endtask

    initial begin
        logic [8:0] r;
        int         lat;
        int         bc;
        int         k;
        int         nd;
        int         cyc;
        int         b0;
        int         b1;
        int         b2;

        reset = 1'b1;
        start = 1'b0;
        sub_r = 1'b0;
        a_r   = '0;
        b_r   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", gw[1].busy, 0);
        check("rst_done", gw[1].done, 0);
        check("rst_sum",  gw[1].sum,  0);
        check("rst_cout", gw[1].cout, 0);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_outputs", {gw[1].busy, gw[1].done, gw[1].cout, gw[1].sum}, 0);
        end

        op8(8'h35, 8'h1C, 1'b0, r, lat, bc);
        check("basic_latency", lat, 9);
        check("basic_busy_cycles", bc, 8);
        check("basic_result", r, 9'h051);

        op8(8'hFF, 8'h01, 1'b0, r, lat, bc);
        check("ovf1_result", r, 9'h100);
        op8(8'hFF, 8'hFF, 1'b0, r, lat, bc);
        check("ovf2_result", r, 9'h1FE);

        a_r   = 32'h0F;
        b_r   = 32'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a_r   = 32'hAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!gw[1].done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ignored_start_latency", k, 5);
        check("ignored_start_result", {gw[1].cout, gw[1].sum}, 9'h010);

        op8(8'h02, 8'h03, 1'b0, r, lat, bc);
        check("b2b_latency", lat, 9);
        check("b2b_result", r, 9'h005);

        a_r   = 32'h80;
        b_r   = 32'h80;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", gw[1].busy, 0);
        check("midrst_sum",  gw[1].sum,  0);
        check("midrst_cout", gw[1].cout, 0);
        reset = 1'b0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (gw[1].done) nd++;
        end
        check("midrst_no_done", nd, 0);

        op8(8'h80, 8'h80, 1'b0, r, lat, bc);
        check("after_rst_latency", lat, 9);
        check("after_rst_result", r, 9'h100);

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h10, 8'h01, 1'b1, r, lat, bc);
        check("sub1_result", r, 9'h10F);
        op8(8'h01, 8'h02, 1'b1, r, lat, bc);
        check("sub2_result", r, 9'h0FF);
        check("sub2_latency", lat, 9);
`endif

        b0  = gw[0].n_done;
        b1  = gw[1].n_done;
        b2  = gw[2].n_done;
        cyc = 0;
        while ((gw[0].n_done - b0 < 200 || gw[1].n_done - b1 < 200 || gw[2].n_done - b2 < 200)
               && cyc < 40000) begin
            start = ($urandom_range(0, 3) == 0);
            a_r   = $urandom;
            b_r   = $urandom;
            sub_r = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("random_budget", (cyc < 40000), 1);
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
